// File: rtl/homomorphic_decrypt_pkg.sv
// he_params_pkg: shared parameters, derived constants and FSM state type for
// the LWE decrypt path.
//   DEF_*          default parameter values for the HE block family
//   delta()        q/p, plaintext step in the ciphertext domain
//   half_delta()   q/(2p), rounding offset
//   quarter_delta() q/(4p), noise-warning threshold
//   state_t        decryptor FSM states
package he_params_pkg;

  localparam int DEF_P     = 64;
  localparam int DEF_PW    = 6;
  localparam int DEF_Q     = 1024;
  localparam int DEF_CW    = 10;
  localparam int DEF_N     = 1;
  localparam int DEF_BIG_N = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_B_WAIT,
    S_DECODE,
    S_OUT
  } state_t;

  function automatic int delta(input int q, input int p);
    return q / p;
  endfunction

  function automatic int half_delta(input int q, input int p);
    return delta(q, p) / 2;
  endfunction

  function automatic int quarter_delta(input int q, input int p);
    return delta(q, p) / 4;
  endfunction

  // Key index width; a single-element key still gets a 1-bit address.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/homomorphic_decrypt_mac.sv
// mod_q_mac: combinational acc_out = (acc_in + a*s) mod q, q = 2^CW.
//   acc_in  running inner-product sum
//   a, s    ciphertext element and matching key element
//   acc_out updated sum, truncated to CW bits
module mod_q_mac #(
  parameter int CW = 10
) (
  input  logic [CW-1:0] acc_in,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] s,
  output logic [CW-1:0] acc_out
);

  logic [CW-1:0] prod;

  // q is a power of two, so the low CW bits of the full 2*CW-bit product
  // are exactly a*s mod q; the upper half is never needed.
  always_comb begin
    prod    = a * s;
    acc_out = acc_in + prod;
  end

endmodule

// File: rtl/homomorphic_decrypt.sv
// homomorphic_decrypt: serial LWE decryptor. Takes a_0..a_{n-1}, b as beats,
// computes phase = b - <a,s> mod q against the stored key and rounds to
// m = round(phase*p/q) mod p.
//   clk, rst_n              clock, async active-low reset
//   sk_wr_en/sk_addr/sk_data key element write (only while idle)
//   ct_valid/ct_ready/ct_data ciphertext beat stream
//   pt_valid/pt_ready/pt_data plaintext result
//   pt_noise_warn           only with DECRYPT_NOISE_FLAG_EN: |noise| >= q/(4p)
//   busy                    FSM not idle
// Optional feature macro: DECRYPT_NOISE_FLAG_EN
module homomorphic_decrypt
  import he_params_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = DEF_P,
  parameter int PLAINTEXT_WIDTH    = DEF_PW,
  parameter int CIPHERTEXT_MODULUS = DEF_Q,
  parameter int CIPHERTEXT_WIDTH   = DEF_CW,
  parameter int DIMENSION          = DEF_N,
  parameter int BIG_N              = DEF_BIG_N,
  localparam int AW = addr_w(DIMENSION)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sk_wr_en,
  input  logic [AW-1:0]               sk_addr,
  input  logic [CIPHERTEXT_WIDTH-1:0] sk_data,
  input  logic                        ct_valid,
  output logic                        ct_ready,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_data,
  output logic                        pt_valid,
  input  logic                        pt_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  pt_data,
`ifdef DECRYPT_NOISE_FLAG_EN
  output logic                        pt_noise_warn,
`endif
  output logic                        busy
);

  localparam int CW     = CIPHERTEXT_WIDTH;
  localparam int PW     = PLAINTEXT_WIDTH;
  localparam int KDEPTH = 1 << AW;

  localparam logic [CW-1:0] HALF_DELTA = CW'(half_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));
  localparam logic [AW:0]   DIM_L      = (AW+1)'(DIMENSION);
  localparam logic [AW-1:0] LAST_IDX   = AW'(DIMENSION - 1);

  if (CW < PW + 2 || BIG_N < 1) begin : g_param_err
    $error("homomorphic_decrypt: invalid parameterisation");
  end

  state_t                   state, state_nx;
  logic [CW-1:0]            acc, phase, mac_acc_in, mac_out, r;
  logic [AW-1:0]            cnt;
  logic [KDEPTH-1:0][CW-1:0] sk_mem;
  logic [PW-1:0]            pt_nx;
  logic                     beat;

  assign beat = ct_valid && ct_ready;
  assign busy = (state != S_IDLE);

  // First beat starts a fresh inner product, so the MAC sees zero there.
  assign mac_acc_in = (state == S_IDLE) ? '0 : acc;

  mod_q_mac #(.CW(CW)) u_mac (
    .acc_in (mac_acc_in),
    .a      (ct_data),
    .s      (sk_mem[cnt]),
    .acc_out(mac_out)
  );

  // Round to nearest plaintext: add q/(2p), keep the top PW bits. The add
  // wraps mod q, which also makes the result wrap mod p.
  always_comb begin
    r     = phase + HALF_DELTA;
    pt_nx = PW'(r >> (CW - PW));
  end

`ifdef DECRYPT_NOISE_FLAG_EN
  localparam int EW = CW - PW + 1;
  localparam logic [EW-1:0] HALF_E    = EW'(half_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));
  localparam logic [EW-1:0] QUARTER_E = EW'(quarter_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));

  logic [EW-1:0] noise_e, noise_mag;
  logic          noise_nx;

  // Noise relative to the rounding centre, as a signed EW-bit value.
  always_comb begin
    noise_e   = {1'b0, r[CW-PW-1:0]} - HALF_E;
    noise_mag = noise_e[EW-1] ? (~noise_e + 1'b1) : noise_e;
    noise_nx  = (noise_mag >= QUARTER_E);
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (beat) state_nx = (DIMENSION == 1) ? S_B_WAIT : S_ACCUM;
      S_ACCUM:  if (beat && cnt == LAST_IDX) state_nx = S_B_WAIT;
      S_B_WAIT: if (beat) state_nx = S_DECODE;
      S_DECODE: state_nx = S_OUT;
      S_OUT:    if (pt_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ct_ready <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      phase    <= '0;
      pt_valid <= 1'b0;
      pt_data  <= '0;
`ifdef DECRYPT_NOISE_FLAG_EN
      pt_noise_warn <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      // Registered so it stays low through reset and rises one cycle later.
      ct_ready <= (state_nx == S_IDLE) || (state_nx == S_ACCUM) || (state_nx == S_B_WAIT);
      case (state)
        S_IDLE, S_ACCUM: begin
          if (beat) begin
            acc <= mac_out;
            cnt <= cnt + 1'b1;
          end
        end
        S_B_WAIT: if (beat) phase <= ct_data - acc;
        S_DECODE: begin
          pt_data  <= pt_nx;
          pt_valid <= 1'b1;
`ifdef DECRYPT_NOISE_FLAG_EN
          pt_noise_warn <= noise_nx;
`endif
        end
        S_OUT: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Key RAM: not reset; writes only while idle and to in-range indices.
  always_ff @(posedge clk) begin
    if (sk_wr_en && !busy && ({1'b0, sk_addr} < DIM_L))
      sk_mem[sk_addr] <= sk_data;
  end

endmodule
